algo_mrnw_bank_chk: RTL and testbench
=====================================

Name: algo_mrnw_bank_chk

Overview:
- Synthesizable, parametrised run-time checker for multiport banked memories with NUMRDPT read ports and NUMWRPT write ports.
- Sits beside the algo core. Observes the same request and response buses the core sees.
- Detects write/write, read/read and optional read/write bank conflicts, and rd_vld latency violations.
- Reports per-cycle error pulses, saturating event counters and a sticky first-error capture readable by test firmware.

Parameters:
- NUMRDPT, 4, number of read ports (>=1)
- NUMWRPT, 6, number of write ports (>=1)
- BITVBNK, 3, bank address width per port
- RD_DELAY, 2, cycles from read to rd_vld (>=1)
- RWCHK, 0, 1 = flag read and write hitting the same bank in the same cycle
- BITCNT, 16, counter width
- BITPRT, 3, port index width; must satisfy 2^BITPRT >= max(NUMRDPT,NUMWRPT)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- clr  in  1  synchronous clear of counters and sticky capture
- ready  in  1  core ready; checks are disabled unless ready==1 (X treated as 0)
- write  in  NUMWRPT  write requests
- wr_badr  in  NUMWRPT*BITVBNK  write bank addresses, port i at bits [i*BITVBNK +: BITVBNK]
- read  in  NUMRDPT  read requests
- rd_badr  in  NUMRDPT*BITVBNK  read bank addresses, same packing as wr_badr
- rd_vld  in  NUMRDPT  read valid returned by core
- err_ww  out  1  registered pulse: write/write conflict
- err_rr  out  1  registered pulse: read/read conflict
- err_rw  out  1  registered pulse: read/write conflict (0 when RWCHK=0)
- err_vld  out  NUMRDPT  registered pulse per port: rd_vld mismatch
- cnt_ww, cnt_rr, cnt_rw, cnt_vld  out  BITCNT each  saturating cycle counters for the four error classes
- first_vld  out  1  sticky: a first error has been captured
- first_type  out  2  error class: 0=ww, 1=rr, 2=rw, 3=vld
- first_pa, first_pb  out  BITPRT each  offending port pair
- first_bank  out  BITVBNK  conflicting bank (0 for vld errors)

Behaviour:
- Reset (rst==0 at clk edge): every output goes to 0 and the read delay pipeline is cleared.
- rst takes precedence over clr.
- Conflict detection (combinational, then registered):
  - ww: write[j]&write[k]&(bank equal), for k<j.
  - rr: the same test on read ports.
  - rw: read[p]&write[w]&(bank equal), evaluated only when RWCHK=1.
  - Detection is gated by ready==1 in the same cycle. Each err_* output is high exactly one cycle after the offending request cycle.
- Read delay pipeline:
  - Per-port shift register of depth RD_DELAY, loaded with read&ready every cycle.
  - Expected valid = pipeline tail.
  - err_vld[p] pulses one cycle after rd_vld[p] != expected[p], evaluated only when ready==1.
  - When ready drops, entries already in flight are still checked when they reach the tail and ready==1.
- Counters:
  - Each counter increments by 1 per cycle in which its class fires. cnt_vld counts cycles, not ports.
  - Counters saturate at all-ones and do not wrap.
- First-error capture:
  - On the first cycle any class fires while first_vld==0, latch that error and set first_vld. All fields update on the same edge as the err_* pulse.
  - Priority among simultaneous errors: ww > rr > rw > vld.
  - Within a class, pick the lowest j, then the lowest k. For rw the pair is (pa=read port, pb=write port). For vld, pa=pb=lowest failing port.
  - first_* holds until clr or reset.
- clr: zeroes counters and first_*. If an error fires in the same cycle as clr, clr wins and the event is discarded. The pipeline is not affected.
- One-port configurations (NUMWRPT=1 or NUMRDPT=1) produce no conflicts for that port type.

Test Plan:
- Reset and idle: rst=0 for 2 cycles, then idle → all outputs 0, first_vld=0.
- Write/write conflict: ready=1, write=6'b000101, w0 and w2 both bank 3 → err_ww=1 next cycle only; cnt_ww=1; first_type=0, first_pa=2, first_pb=0, first_bank=3.
- Simultaneous classes: ww and rr conflicts in the same cycle, then another ww 3 cycles later → err_ww and err_rr pulse together; first_type=0 and does not change; cnt_ww=2, cnt_rr=1.
- Ready gating: the same conflict as the ww test with ready=0 → no pulses, counters unchanged.
- Valid latency: RD_DELAY=2, read[1] at cycle 10, core asserts rd_vld[1] at cycle 11 instead of 12 → err_vld=4'b0010 at cycle 12 and again at 13; cnt_vld=2; first_type=3, first_pa=1.
- rw check and saturation: RWCHK=1 with r0 and w4 both bank 5 → err_rw pulses. With BITCNT=2, 5 consecutive conflict cycles → counter stops at 3. Asserting clr → counters=0, first_vld=0.

Source files
------------

// File: rtl/algo_mrnw_bank_chk_if.sv
// ---------------------------------------------------------------------------
// algo_mrnw_bank_chk_if
// Request/response bus of a multiport banked memory core as seen by the
// run-time checker. The checker only observes, so it takes the slave view.
//   ready    core ready (checks are active only while ready==1)
//   write    per-port write requests           [NUMWRPT]
//   wr_badr  write bank addresses, packed       [NUMWRPT*BITVBNK]
//   read     per-port read requests            [NUMRDPT]
//   rd_badr  read bank addresses, packed        [NUMRDPT*BITVBNK]
//   rd_vld   per-port read valid from the core  [NUMRDPT]
// ---------------------------------------------------------------------------
interface algo_mrnw_bank_chk_if #(
   parameter int NUMRDPT = 4,
   parameter int NUMWRPT = 6,
   parameter int BITVBNK = 3
);
   logic                         ready;
   logic [NUMWRPT-1:0]           write;
   logic [NUMWRPT*BITVBNK-1:0]   wr_badr;
   logic [NUMRDPT-1:0]           read;
   logic [NUMRDPT*BITVBNK-1:0]   rd_badr;
   logic [NUMRDPT-1:0]           rd_vld;

   modport master (
      output ready, write, wr_badr, read, rd_badr, rd_vld
   );

   modport slave (
      input  ready, write, wr_badr, read, rd_badr, rd_vld
   );
endinterface

// File: rtl/algo_mrnw_bank_chk.sv
// ---------------------------------------------------------------------------
// algo_mrnw_bank_chk
// Run-time checker for a multiport banked memory. Watches the request bus of
// the core and flags write/write, read/read and (optionally) read/write bank
// conflicts, plus read-valid latency mismatches.
//   clk, rst     clock, synchronous active-low reset
//   clr          synchronous clear of counters and first-error capture
//   bus          observed core bus (slave view)
//   err_ww/rr/rw registered one-cycle conflict pulses
//   err_vld      registered per-port rd_vld mismatch pulses
//   cnt_*        saturating per-class event counters (cycles with an error)
//   first_*      sticky capture of the first error: class, port pair, bank
// ---------------------------------------------------------------------------
module algo_mrnw_bank_chk #(
   parameter int NUMRDPT  = 4,
   parameter int NUMWRPT  = 6,
   parameter int BITVBNK  = 3,
   parameter int RD_DELAY = 2,
   parameter int RWCHK    = 0,
   parameter int BITCNT   = 16,
   parameter int BITPRT   = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   algo_mrnw_bank_chk_if.slave  bus,
   output logic                 err_ww,
   output logic                 err_rr,
   output logic                 err_rw,
   output logic [NUMRDPT-1:0]   err_vld,
   output logic [BITCNT-1:0]    cnt_ww,
   output logic [BITCNT-1:0]    cnt_rr,
   output logic [BITCNT-1:0]    cnt_rw,
   output logic [BITCNT-1:0]    cnt_vld,
   output logic                 first_vld,
   output logic [1:0]           first_type,
   output logic [BITPRT-1:0]    first_pa,
   output logic [BITPRT-1:0]    first_pb,
   output logic [BITVBNK-1:0]   first_bank
);

   localparam logic [1:0] TYPE_WW  = 2'd0;
   localparam logic [1:0] TYPE_RR  = 2'd1;
   localparam logic [1:0] TYPE_RW  = 2'd2;
   localparam logic [1:0] TYPE_VLD = 2'd3;

   function automatic logic [BITCNT-1:0] sat_inc(input logic [BITCNT-1:0] cnt,
                                                 input logic              hit);
      if (hit && (cnt != {BITCNT{1'b1}}))
         return cnt + BITCNT'(1);
      return cnt;
   endfunction

   logic                  rdy_p0;
   logic                  ww_hit_p0, rr_hit_p0, rw_hit_p0, any_hit_p0;
   logic [BITPRT-1:0]     ww_pa_p0, ww_pb_p0, rr_pa_p0, rr_pb_p0, rw_pa_p0, rw_pb_p0;
   logic [BITVBNK-1:0]    ww_bank_p0, rr_bank_p0, rw_bank_p0;
   logic [NUMRDPT-1:0]    vld_mis_p0;
   logic [BITPRT-1:0]     vld_port_p0;
   logic [NUMRDPT-1:0]    vld_tail;
   logic [NUMRDPT-1:0]    vld_pipe [RD_DELAY];

   assign vld_tail = vld_pipe[RD_DELAY-1];

   // ---- stage p0: combinational conflict search on the live request bus ----
   // Outer loop ascending in j and the "not yet found" guard make the first hit
   // the lowest j, then lowest k, which is the pair reported in first_*.
   always_comb begin
      rdy_p0 = 1'b0;
      if (bus.ready)
         rdy_p0 = 1'b1;   // an unknown ready takes the else path in simulation

      ww_hit_p0 = 1'b0; ww_pa_p0 = '0; ww_pb_p0 = '0; ww_bank_p0 = '0;
      for (int j = 1; j < NUMWRPT; j++) begin
         for (int k = 0; k < j; k++) begin
            if (!ww_hit_p0 && rdy_p0 && bus.write[j] && bus.write[k] &&
                (bus.wr_badr[j*BITVBNK +: BITVBNK] == bus.wr_badr[k*BITVBNK +: BITVBNK])) begin
               ww_hit_p0  = 1'b1;
               ww_pa_p0   = BITPRT'(j);
               ww_pb_p0   = BITPRT'(k);
               ww_bank_p0 = bus.wr_badr[j*BITVBNK +: BITVBNK];
            end
         end
      end

      rr_hit_p0 = 1'b0; rr_pa_p0 = '0; rr_pb_p0 = '0; rr_bank_p0 = '0;
      for (int j = 1; j < NUMRDPT; j++) begin
         for (int k = 0; k < j; k++) begin
            if (!rr_hit_p0 && rdy_p0 && bus.read[j] && bus.read[k] &&
                (bus.rd_badr[j*BITVBNK +: BITVBNK] == bus.rd_badr[k*BITVBNK +: BITVBNK])) begin
               rr_hit_p0  = 1'b1;
               rr_pa_p0   = BITPRT'(j);
               rr_pb_p0   = BITPRT'(k);
               rr_bank_p0 = bus.rd_badr[j*BITVBNK +: BITVBNK];
            end
         end
      end

      rw_hit_p0 = 1'b0; rw_pa_p0 = '0; rw_pb_p0 = '0; rw_bank_p0 = '0;
      if (RWCHK != 0) begin
         for (int p = 0; p < NUMRDPT; p++) begin
            for (int w = 0; w < NUMWRPT; w++) begin
               if (!rw_hit_p0 && rdy_p0 && bus.read[p] && bus.write[w] &&
                   (bus.rd_badr[p*BITVBNK +: BITVBNK] == bus.wr_badr[w*BITVBNK +: BITVBNK])) begin
                  rw_hit_p0  = 1'b1;
                  rw_pa_p0   = BITPRT'(p);
                  rw_pb_p0   = BITPRT'(w);
                  rw_bank_p0 = bus.rd_badr[p*BITVBNK +: BITVBNK];
               end
            end
         end
      end

      vld_mis_p0 = rdy_p0 ? (bus.rd_vld ^ vld_tail) : '0;
      vld_port_p0 = '0;
      for (int p = NUMRDPT-1; p >= 0; p--) begin
         if (vld_mis_p0[p])
            vld_port_p0 = BITPRT'(p);
      end

      any_hit_p0 = ww_hit_p0 | rr_hit_p0 | rw_hit_p0 | (|vld_mis_p0);
   end

   // ---- read-delay pipeline: expected rd_vld arrives RD_DELAY cycles later ----
   // Loaded every cycle (zeros while not ready) so in-flight entries keep
   // moving and are checked at the tail whenever ready is high again.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < RD_DELAY; i++)
            vld_pipe[i] <= '0;
      end else begin
         vld_pipe[0] <= bus.read & {NUMRDPT{rdy_p0}};
         for (int i = 1; i < RD_DELAY; i++)
            vld_pipe[i] <= vld_pipe[i-1];
      end
   end

   // ---- stage p1: registered pulses, counters and first-error capture ----
   always_ff @(posedge clk) begin
      if (!rst) begin
         err_ww     <= 1'b0;
         err_rr     <= 1'b0;
         err_rw     <= 1'b0;
         err_vld    <= '0;
         cnt_ww     <= '0;
         cnt_rr     <= '0;
         cnt_rw     <= '0;
         cnt_vld    <= '0;
         first_vld  <= 1'b0;
         first_type <= '0;
         first_pa   <= '0;
         first_pb   <= '0;
         first_bank <= '0;
      end else begin
         err_ww  <= ww_hit_p0;
         err_rr  <= rr_hit_p0;
         err_rw  <= rw_hit_p0;
         err_vld <= vld_mis_p0;
         if (clr) begin
            cnt_ww     <= '0;
            cnt_rr     <= '0;
            cnt_rw     <= '0;
            cnt_vld    <= '0;
            first_vld  <= 1'b0;
            first_type <= '0;
            first_pa   <= '0;
            first_pb   <= '0;
            first_bank <= '0;
         end else begin
            cnt_ww  <= sat_inc(cnt_ww,  ww_hit_p0);
            cnt_rr  <= sat_inc(cnt_rr,  rr_hit_p0);
            cnt_rw  <= sat_inc(cnt_rw,  rw_hit_p0);
            cnt_vld <= sat_inc(cnt_vld, |vld_mis_p0);
            if (!first_vld && any_hit_p0) begin
               first_vld <= 1'b1;
               if (ww_hit_p0) begin
                  first_type <= TYPE_WW;
                  first_pa   <= ww_pa_p0;
                  first_pb   <= ww_pb_p0;
                  first_bank <= ww_bank_p0;
               end else if (rr_hit_p0) begin
                  first_type <= TYPE_RR;
                  first_pa   <= rr_pa_p0;
                  first_pb   <= rr_pb_p0;
                  first_bank <= rr_bank_p0;
               end else if (rw_hit_p0) begin
                  first_type <= TYPE_RW;
                  first_pa   <= rw_pa_p0;
                  first_pb   <= rw_pb_p0;
                  first_bank <= rw_bank_p0;
               end else begin
                  first_type <= TYPE_VLD;
                  first_pa   <= vld_port_p0;
                  first_pb   <= vld_port_p0;
                  first_bank <= '0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_algo_mrnw_bank_chk.sv
`timescale 1ns/1ps
// Bench for algo_mrnw_bank_chk: two checker instances share one bus, the
// default configuration and one with RWCHK=1, BITCNT=2. A behavioural model
// lists every error event of a cycle in priority order; expected outputs are
// queued per instance and popped by a monitor after each clock edge.
module tb_algo_mrnw_bank_chk;
   localparam int NR = 4;
   localparam int NW = 6;
   localparam int BV = 3;
   localparam int RD = 2;
   localparam int BP = 3;

   typedef struct {
      logic          ww, rr, rw;
      logic [NR-1:0] vld;
      int            cww, crr, crw, cvld;
      logic          fv;
      logic [1:0]    ft;
      int            fa, fb, fbank;
   } res_t;

   typedef struct { int cls; int pa; int pb; int bank; } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic clr = 1'b0;
   always #5 clk = ~clk;

   algo_mrnw_bank_chk_if #(.NUMRDPT(NR), .NUMWRPT(NW), .BITVBNK(BV)) bus ();

   logic          err_ww0, err_rr0, err_rw0, err_ww1, err_rr1, err_rw1;
   logic [NR-1:0] err_vld0, err_vld1;
   logic [15:0]   cnt_ww0, cnt_rr0, cnt_rw0, cnt_vld0;
   logic [1:0]    cnt_ww1, cnt_rr1, cnt_rw1, cnt_vld1;
   logic          first_vld0, first_vld1;
   logic [1:0]    first_type0, first_type1;
   logic [BP-1:0] first_pa0, first_pb0, first_pa1, first_pb1;
   logic [BV-1:0] first_bank0, first_bank1;

   algo_mrnw_bank_chk #(.NUMRDPT(NR), .NUMWRPT(NW), .BITVBNK(BV), .RD_DELAY(RD),
                        .RWCHK(0), .BITCNT(16), .BITPRT(BP)) dut0 (
      .clk(clk), .rst(rst), .clr(clr), .bus(bus),
      .err_ww(err_ww0), .err_rr(err_rr0), .err_rw(err_rw0), .err_vld(err_vld0),
      .cnt_ww(cnt_ww0), .cnt_rr(cnt_rr0), .cnt_rw(cnt_rw0), .cnt_vld(cnt_vld0),
      .first_vld(first_vld0), .first_type(first_type0), .first_pa(first_pa0),
      .first_pb(first_pb0), .first_bank(first_bank0));

   algo_mrnw_bank_chk #(.NUMRDPT(NR), .NUMWRPT(NW), .BITVBNK(BV), .RD_DELAY(RD),
                        .RWCHK(1), .BITCNT(2), .BITPRT(BP)) dut1 (
      .clk(clk), .rst(rst), .clr(clr), .bus(bus),
      .err_ww(err_ww1), .err_rr(err_rr1), .err_rw(err_rw1), .err_vld(err_vld1),
      .cnt_ww(cnt_ww1), .cnt_rr(cnt_rr1), .cnt_rw(cnt_rw1), .cnt_vld(cnt_vld1),
      .first_vld(first_vld1), .first_type(first_type1), .first_pa(first_pa1),
      .first_pb(first_pb1), .first_bank(first_bank1));

   int total = 0;
   int bad   = 0;

   // model state
   res_t          ms [2];
   int            cap [2] = '{65535, 3};
   logic [NR-1:0] rd_req [0:4095];
   int            cyc = 0;
   int            last_rst = 0;
   res_t          q0 [$];
   res_t          q1 [$];

   function automatic logic [NR-1:0] exp_tail();
      int src;
      src = cyc - RD;
      if (src > last_rst)
         return rd_req[src];
      return '0;
   endfunction

   function automatic int wbank(input logic [NW*BV-1:0] v, input int j);
      return int'(v[j*BV +: BV]);
   endfunction

   function automatic int rbank(input logic [NR*BV-1:0] v, input int j);
      return int'(v[j*BV +: BV]);
   endfunction

   function automatic int sat(input int c, input logic inc, input int mx);
      return (c + int'(inc) > mx) ? mx : c + int'(inc);
   endfunction

   task automatic model_step(input logic r_n, input logic c, input logic rdy_in,
                             input logic [NW-1:0] w, input logic [NW*BV-1:0] wb,
                             input logic [NR-1:0] r, input logic [NR*BV-1:0] rb,
                             input logic [NR-1:0] rv);
      ev_t           evs [$];
      ev_t           e;
      logic          rdy;
      logic [NR-1:0] ex, mis;
      res_t          n;
      rdy = (rdy_in === 1'b1);
      ex  = exp_tail();
      rd_req[cyc] = (r_n && rdy) ? r : '0;
      mis = rdy ? (rv ^ ex) : '0;
      if (rdy) begin
         for (int j = 0; j < NW; j++)
            for (int k = 0; k < j; k++)
               if (w[j] && w[k] && wbank(wb, j) == wbank(wb, k)) begin
                  e = '{0, j, k, wbank(wb, j)}; evs.push_back(e);
               end
         for (int j = 0; j < NR; j++)
            for (int k = 0; k < j; k++)
               if (r[j] && r[k] && rbank(rb, j) == rbank(rb, k)) begin
                  e = '{1, j, k, rbank(rb, j)}; evs.push_back(e);
               end
         for (int p = 0; p < NR; p++)
            for (int q = 0; q < NW; q++)
               if (r[p] && w[q] && rbank(rb, p) == wbank(wb, q)) begin
                  e = '{2, p, q, rbank(rb, p)}; evs.push_back(e);
               end
         for (int p = 0; p < NR; p++)
            if (mis[p]) begin
               e = '{3, p, p, 0}; evs.push_back(e);
            end
      end
      if (!r_n) last_rst = cyc;
      for (int i = 0; i < 2; i++) begin
         n = ms[i];
         if (!r_n) begin
            n = '{default: 0};
         end else begin
            n.ww = 1'b0; n.rr = 1'b0; n.rw = 1'b0; n.vld = mis;
            foreach (evs[x]) begin
               if (evs[x].cls == 0) n.ww = 1'b1;
               if (evs[x].cls == 1) n.rr = 1'b1;
               if (evs[x].cls == 2 && i == 1) n.rw = 1'b1;
            end
            if (c) begin
               n.cww = 0; n.crr = 0; n.crw = 0; n.cvld = 0;
               n.fv = 1'b0; n.ft = 2'd0; n.fa = 0; n.fb = 0; n.fbank = 0;
            end else begin
               n.cww  = sat(n.cww,  n.ww,  cap[i]);
               n.crr  = sat(n.crr,  n.rr,  cap[i]);
               n.crw  = sat(n.crw,  n.rw,  cap[i]);
               n.cvld = sat(n.cvld, |mis,  cap[i]);
               if (!n.fv) begin
                  foreach (evs[x]) begin
                     if (!n.fv && (evs[x].cls != 2 || i == 1)) begin
                        n.fv = 1'b1; n.ft = 2'(evs[x].cls);
                        n.fa = evs[x].pa; n.fb = evs[x].pb; n.fbank = evs[x].bank;
                     end
                  end
               end
            end
         end
         ms[i] = n;
      end
      q0.push_back(ms[0]);
      q1.push_back(ms[1]);
   endtask

   function automatic res_t get_act(input int inst);
      res_t a;
      if (inst == 0) begin
         a.ww = err_ww0; a.rr = err_rr0; a.rw = err_rw0; a.vld = err_vld0;
         a.cww = int'(cnt_ww0); a.crr = int'(cnt_rr0); a.crw = int'(cnt_rw0); a.cvld = int'(cnt_vld0);
         a.fv = first_vld0; a.ft = first_type0; a.fa = int'(first_pa0);
         a.fb = int'(first_pb0); a.fbank = int'(first_bank0);
      end else begin
         a.ww = err_ww1; a.rr = err_rr1; a.rw = err_rw1; a.vld = err_vld1;
         a.cww = int'(cnt_ww1); a.crr = int'(cnt_rr1); a.crw = int'(cnt_rw1); a.cvld = int'(cnt_vld1);
         a.fv = first_vld1; a.ft = first_type1; a.fa = int'(first_pa1);
         a.fb = int'(first_pb1); a.fbank = int'(first_bank1);
      end
      return a;
   endfunction

   task automatic compare(input int inst, input res_t e);
      res_t a;
      a = get_act(inst);
      total++;
      if ({a.ww, a.rr, a.rw, a.vld} !== {e.ww, e.rr, e.rw, e.vld}) begin
         bad++;
         $display("FAIL sb%0d err cyc=%0d: got ww=%b rr=%b rw=%b vld=%b want ww=%b rr=%b rw=%b vld=%b",
                  inst, cyc, a.ww, a.rr, a.rw, a.vld, e.ww, e.rr, e.rw, e.vld);
      end
      total++;
      if (a.cww != e.cww || a.crr != e.crr || a.crw != e.crw || a.cvld != e.cvld) begin
         bad++;
         $display("FAIL sb%0d cnt cyc=%0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                  inst, cyc, a.cww, a.crr, a.crw, a.cvld, e.cww, e.crr, e.crw, e.cvld);
      end
      total++;
      if (a.fv !== e.fv || a.ft !== e.ft || a.fa != e.fa || a.fb != e.fb || a.fbank != e.fbank) begin
         bad++;
         $display("FAIL sb%0d first cyc=%0d: got v=%b t=%0d pa=%0d pb=%0d bk=%0d want v=%b t=%0d pa=%0d pb=%0d bk=%0d",
                  inst, cyc, a.fv, a.ft, a.fa, a.fb, a.fbank, e.fv, e.ft, e.fa, e.fb, e.fbank);
      end
   endtask

   // monitor: one expected entry per clock edge driven by the stimulus
   always @(posedge clk) begin
      #1;
      if (q0.size() > 0) compare(0, q0.pop_front());
      if (q1.size() > 0) compare(1, q1.pop_front());
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic cycle(input logic r_n, input logic c, input logic rdy,
                        input logic [NW-1:0] w, input logic [NW*BV-1:0] wb,
                        input logic [NR-1:0] r, input logic [NR*BV-1:0] rb,
                        input logic [NR-1:0] vflip);
      logic [NR-1:0] rv;
      @(negedge clk);
      rv = exp_tail() ^ vflip;
      rst = r_n; clr = c;
      bus.ready = rdy; bus.write = w; bus.wr_badr = wb;
      bus.read = r; bus.rd_badr = rb; bus.rd_vld = rv;
      model_step(r_n, c, rdy, w, wb, r, rb, rv);
      cyc++;
   endtask

   task automatic idle(input logic c);
      cycle(1'b1, c, 1'b1, '0, '0, '0, '0, '0);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [NW*BV-1:0] wb;
      logic [NR*BV-1:0] rb;
      logic [NR-1:0]    vf;
      bus.ready = 1'b0; bus.write = '0; bus.wr_badr = '0;
      bus.read = '0; bus.rd_badr = '0; bus.rd_vld = '0;

      // reset and idle
      cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
      cycle(1'b0, 1'b1, 1'b1, '0, '0, '0, '0, '0);
      after_edge();
      chk("rst_err_ww", 32'(err_ww0), 0);
      chk("rst_cnt_ww", 32'(cnt_ww0), 0);
      chk("rst_first_vld", 32'(first_vld0), 0);
      idle(1'b0);
      idle(1'b0);

      // write/write conflict, w0 and w2 on bank 3
      wb = '0; wb[0*BV +: BV] = 3'd3; wb[2*BV +: BV] = 3'd3;
      cycle(1'b1, 1'b0, 1'b1, 6'b000101, wb, '0, '0, '0);
      after_edge();
      chk("ww_pulse", 32'(err_ww0), 1);
      chk("ww_cnt", 32'(cnt_ww0), 1);
      chk("ww_first_type", 32'(first_type0), 0);
      chk("ww_first_pa", 32'(first_pa0), 2);
      chk("ww_first_pb", 32'(first_pb0), 0);
      chk("ww_first_bank", 32'(first_bank0), 3);
      idle(1'b0);
      after_edge();
      chk("ww_one_cycle", 32'(err_ww0), 0);

      // simultaneous ww+rr, then ww again three cycles later
      idle(1'b1);
      rb = '0; rb[0*BV +: BV] = 3'd6; rb[1*BV +: BV] = 3'd6;
      cycle(1'b1, 1'b0, 1'b1, 6'b000101, wb, 4'b0011, rb, '0);
      after_edge();
      chk("sim_ww", 32'(err_ww0), 1);
      chk("sim_rr", 32'(err_rr0), 1);
      chk("sim_first_type", 32'(first_type0), 0);
      idle(1'b0);
      idle(1'b0);
      cycle(1'b1, 1'b0, 1'b1, 6'b000101, wb, '0, '0, '0);
      after_edge();
      chk("sim_cnt_ww", 32'(cnt_ww0), 2);
      chk("sim_cnt_rr", 32'(cnt_rr0), 1);
      chk("sim_first_hold", 32'(first_type0), 0);

      // ready gating
      cycle(1'b1, 1'b0, 1'b0, 6'b000101, wb, '0, '0, '0);
      after_edge();
      chk("gate_pulse", 32'(err_ww0), 0);
      chk("gate_cnt", 32'(cnt_ww0), 2);

      // rd_vld one cycle early on port 1
      idle(1'b1);
      idle(1'b0);
      cycle(1'b1, 1'b0, 1'b1, '0, '0, 4'b0010, '0, '0);
      cycle(1'b1, 1'b0, 1'b1, '0, '0, '0, '0, 4'b0010);
      after_edge();
      chk("vld_early", 32'(err_vld0), 32'b0010);
      chk("vld_first_type", 32'(first_type0), 3);
      chk("vld_first_pa", 32'(first_pa0), 1);
      cycle(1'b1, 1'b0, 1'b1, '0, '0, '0, '0, 4'b0010);
      after_edge();
      chk("vld_missing", 32'(err_vld0), 32'b0010);
      chk("vld_cnt", 32'(cnt_vld0), 2);

      // rw conflict with saturation on the 2-bit instance
      idle(1'b1);
      idle(1'b0);
      idle(1'b0);
      wb = '0; wb[4*BV +: BV] = 3'd5;
      rb = '0; rb[0*BV +: BV] = 3'd5;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b0, 1'b1, 6'b010000, wb, 4'b0001, rb, '0);
         after_edge();
         chk("rw_pulse1", 32'(err_rw1), 1);
         chk("rw_pulse0", 32'(err_rw0), 0);
      end
      chk("rw_sat", 32'(cnt_rw1), 3);
      chk("rw_first_pb", 32'(first_pb1), 4);
      idle(1'b1);
      after_edge();
      chk("clr_cnt", 32'(cnt_rw1), 0);
      chk("clr_first", 32'(first_vld1), 0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [NW-1:0] w;
         logic [NR-1:0] r;
         for (int p = 0; p < NW; p++) begin
            w[p] = ($urandom_range(0, 3) == 0);
            wb[p*BV +: BV] = BV'($urandom_range(0, 7));
         end
         for (int p = 0; p < NR; p++) begin
            r[p] = ($urandom_range(0, 2) == 0);
            rb[p*BV +: BV] = BV'($urandom_range(0, 7));
         end
         vf = '0;
         if ($urandom_range(0, 14) == 0) vf[$urandom_range(0, NR-1)] = 1'b1;
         cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 29) == 0),
               ($urandom_range(0, 3) != 0), w, wb, r, rb, vf);
      end

      idle(1'b0);
      idle(1'b0);
      after_edge();
      @(posedge clk);
      #3;
      chk("queue_drained", 32'(q0.size() + q1.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
